// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Inter-stage pipeline register for FlowLine (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   Carries a payload word plus a side-band metadata word (usually the PC).
//   It has a valid bit, flush-to-bubble and stall-hold. A warm-up window
//   forces bubbles for WARMUP_CYCLES edges after reset release.
//
// Parameters
//   DATA_W        payload width
//   META_W        metadata width
//   NOP_VALUE     bubble payload, truncated or zero-extended to DATA_W
//   WARMUP_CYCLES bubble edges forced after reset release (0..15)
//
// Ports
//   clk, rst_n            clock (rising edge) / async active-low reset
//   stall                 hold all registered state this edge
//   flush                 load a bubble instead of the incoming payload
//   in_valid/data/meta    upstream payload, valid flag and metadata
//   out_valid/data/meta   registered payload, valid flag and metadata
//   warmup_busy           high while the warm-up window is active
//   perf_stall_cnt        (PIPE_STAGE_PERF_EN only) saturating stall count
//   perf_flush_cnt        (PIPE_STAGE_PERF_EN only) saturating flush count
//
// Build option: define PIPE_STAGE_PERF_EN to add the two performance counters.

module pipe_stage_reg #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned META_W        = 32,
  parameter logic [31:0] NOP_VALUE     = 32'h0000_0013,
  parameter int unsigned WARMUP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [META_W-1:0] in_meta,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [META_W-1:0] out_meta,
  output logic              warmup_busy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]       perf_stall_cnt,
  output logic [15:0]       perf_flush_cnt
`endif
);

  localparam logic [DATA_W-1:0] NOP_D     = DATA_W'(NOP_VALUE);
  localparam logic [3:0]        WARM_INIT = 4'(WARMUP_CYCLES);
  localparam logic              BUSY_INIT = (WARMUP_CYCLES != 0);

  logic [3:0] wcnt;
  logic       warm_active;

  assign warm_active = (wcnt != 4'd0);

  // Warm-up runs regardless of stall. With WARMUP_CYCLES=0 it resets to zero
  // and never moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt        <= WARM_INIT;
      warmup_busy <= BUSY_INIT;
    end else begin
      if (warm_active) begin
        wcnt <= wcnt - 4'd1;
      end
      // Registered view of the post-edge count being non-zero.
      warmup_busy <= (wcnt > 4'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= NOP_D;
    end else if (warm_active || flush) begin
      out_valid <= 1'b0;
      out_data  <= NOP_D;
    end else if (!stall) begin
      // A non-valid input passes its data through untouched.
      out_valid <= in_valid;
      out_data  <= in_data;
    end
  end

  // Metadata keeps following the PC through bubbles; only stall holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_meta <= '0;
    end else if (!stall) begin
      out_meta <= in_meta;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // A stall overridden by flush is not a real stall. Flushes during warm-up
  // are not counted because warm-up already produces the bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall && !flush && (perf_stall_cnt != 16'hFFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      end
      if (flush && !warm_active && (perf_flush_cnt != 16'hFFFF)) begin
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int W = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [31:0] in_meta = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [31:0] out_meta;
  logic        warmup_busy;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  int checks = 0;
  int failures = 0;

  pipe_stage_reg #(
    .DATA_W(32), .META_W(32), .NOP_VALUE(NOP), .WARMUP_CYCLES(W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_meta(in_meta),
    .out_valid(out_valid), .out_data(out_data), .out_meta(out_meta),
    .warmup_busy(warmup_busy)
`ifdef PIPE_STAGE_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: counts edges since reset release and applies the
  // priority rules directly.
  int          m_edges;
  logic        m_valid;
  logic [31:0] m_data;
  logic [31:0] m_meta;
  logic        m_busy;
  int          m_pstall;
  int          m_pflush;
  logic        preload = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges  <= 0;
      m_valid  <= 1'b0;
      m_data   <= NOP;
      m_meta   <= '0;
      m_busy   <= (W != 0);
      m_pstall <= 0;
      m_pflush <= 0;
    end else begin
      if (m_edges < W || flush) begin
        m_valid <= 1'b0;
        m_data  <= NOP;
      end else if (!stall) begin
        m_valid <= in_valid;
        m_data  <= in_data;
      end
      if (!stall) m_meta <= in_meta;
      m_edges <= m_edges + 1;
      m_busy  <= (m_edges + 1 < W);
      if (stall && !flush) m_pstall <= ((preload ? 65535 : m_pstall) + 1 > 65535) ? 65535 : (preload ? 65535 : m_pstall) + 1;
      else if (preload) m_pstall <= 65535;
      if (flush && m_edges >= W) m_pflush <= (m_pflush + 1 > 65535) ? 65535 : m_pflush + 1;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_valid", {63'd0, out_valid}, {63'd0, m_valid});
    chk("model_data", {32'd0, out_data}, {32'd0, m_data});
    chk("model_meta", {32'd0, out_meta}, {32'd0, m_meta});
    chk("model_busy", {63'd0, warmup_busy}, {63'd0, m_busy});
`ifdef PIPE_STAGE_PERF_EN
    if (!preload) begin
      chk("model_pstall", {48'd0, perf_stall_cnt}, 64'(m_pstall));
      chk("model_pflush", {48'd0, perf_flush_cnt}, 64'(m_pflush));
    end
`endif
  end

  task automatic edge1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [31:0] d, input logic [31:0] m);
    chk({name, "_valid"}, {63'd0, out_valid}, {63'd0, v});
    chk({name, "_data"}, {32'd0, out_data}, {32'd0, d});
    chk({name, "_meta"}, {32'd0, out_meta}, {32'd0, m});
  endtask

  initial begin
    in_valid = 1'b1;
    in_data  = 32'hAAAA_0001;
    in_meta  = 32'h100;
    #23;
    chk_out("reset", 1'b0, 32'h13, 32'h0);
    chk("reset_busy", {63'd0, warmup_busy}, 64'd1);
    rst_n = 1'b1;

    edge1;
    chk_out("warm_e1", 1'b0, 32'h13, 32'h100);
    chk("warm_e1_busy", {63'd0, warmup_busy}, 64'd1);
    edge1;
    chk_out("warm_e2", 1'b0, 32'h13, 32'h100);
    chk("warm_e2_busy", {63'd0, warmup_busy}, 64'd0);
    edge1;
    chk_out("warm_e3", 1'b1, 32'hAAAA_0001, 32'h100);

    in_data = 32'h1111_1111; in_meta = 32'h104;
    edge1;
    chk_out("load", 1'b1, 32'h1111_1111, 32'h104);
    stall = 1'b1; in_data = 32'h2222_2222; in_meta = 32'h108;
    for (int i = 0; i < 3; i++) begin
      edge1;
      chk_out("stall_hold", 1'b1, 32'h1111_1111, 32'h104);
    end
    stall = 1'b0;
    edge1;
    chk_out("stall_release", 1'b1, 32'h2222_2222, 32'h108);

    flush = 1'b1; in_data = 32'h3333_3333; in_meta = 32'h200;
    edge1;
    chk_out("flush", 1'b0, 32'h13, 32'h200);

    flush = 1'b0; in_data = 32'h4444_4444; in_meta = 32'h300;
    edge1;
    chk_out("pre_fs", 1'b1, 32'h4444_4444, 32'h300);
    flush = 1'b1; stall = 1'b1; in_data = 32'h5555_5555; in_meta = 32'h400;
    edge1;
    chk_out("flush_stall", 1'b0, 32'h13, 32'h300);

    flush = 1'b0; stall = 1'b0; in_valid = 1'b0; in_data = 32'h6666_6666; in_meta = 32'h404;
    edge1;
    chk_out("invalid_pass", 1'b0, 32'h6666_6666, 32'h404);

    in_valid = 1'b1; in_data = 32'h7777_7777; in_meta = 32'h500;
    edge1;
    chk_out("pre_rst", 1'b1, 32'h7777_7777, 32'h500);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 32'h13, 32'h0);
    chk("async_rst_busy", {63'd0, warmup_busy}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    edge1;
    chk_out("rewarm_e1", 1'b0, 32'h13, 32'h500);
    edge1;
    chk_out("rewarm_e2", 1'b0, 32'h13, 32'h500);
    edge1;
    chk_out("rewarm_e3", 1'b1, 32'h7777_7777, 32'h500);

`ifdef PIPE_STAGE_PERF_EN
    stall = 1'b1;
    for (int i = 0; i < 5; i++) edge1;
    stall = 1'b0; flush = 1'b1;
    for (int i = 0; i < 2; i++) edge1;
    stall = 1'b1;
    edge1;
    stall = 1'b0; flush = 1'b0;
    chk("perf_stall_5", {48'd0, perf_stall_cnt}, 64'd5);
    chk("perf_flush_3", {48'd0, perf_flush_cnt}, 64'd3);
    preload = 1'b1;
    force dut.perf_stall_cnt = 16'hFFFF;
    #1 release dut.perf_stall_cnt;
    stall = 1'b1;
    edge1;
    preload = 1'b0;
    stall = 1'b0;
    chk("perf_stall_sat", {48'd0, perf_stall_cnt}, 64'hFFFF);
`endif

    edge1;
    edge1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
